aes_round_sched: RTL and testbench

Iterative round sequencer for the AES encryption core. It accepts one 128-bit plaintext block, performs the initial AddRoundKey with round key 0, then drives a single shared round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey pipeline) NR times, fetching one round key per pass from the key store. It returns the ciphertext on a valid/ready output port. It sits between the block-level input/output handshake and the round datapath plus key store, and owns all round counting and final-round control.

---
 rtl/aes_round_sched.sv | 109 ++++++++++
 tb/tb_aes_round_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sched.sv
// Iterative AES round sequencer: initial AddRoundKey, then NR passes through a shared
// external round datapath with per-round key fetch, returning the ciphertext on valid/ready.
module aes_round_sched #(
    parameter int DATA_LEN = 128,
    parameter int NR       = 10,
    parameter int TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_data,
    output logic [3:0]          key_idx,
    input  logic [DATA_LEN-1:0] key_data,
    output logic                rnd_valid_in,
    output logic [DATA_LEN-1:0] rnd_data_in,
    output logic                rnd_key_valid,
    output logic [DATA_LEN-1:0] rnd_key,
    output logic                rnd_final,
    input  logic                rnd_valid_out,
    input  logic [DATA_LEN-1:0] rnd_data_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data,
    output logic                busy,
    output logic                err_timeout,
    output logic                err_spurious
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0]        LAST_ROUND = 4'(NR);
    localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(TIMEOUT - 1);

    logic [1:0]          state;
    logic [DATA_LEN-1:0] state_reg;
    logic [3:0]          rcnt;
    logic [WCNT_W-1:0]   wcnt;

    // NOTE: state_reg is reset too because it is visible on out_data/rnd_data_in,
    // which must read zero straight out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            state_reg    <= '0;
            rcnt         <= 4'd1;
            wcnt         <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            // A round result is only meaningful while a launch is outstanding.
            if (rnd_valid_out && (state != WAIT))
                err_spurious <= 1'b1;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= in_data ^ key_data;
                        rcnt      <= 4'd1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the expiry cycle still wins over the timeout.
                    if (rnd_valid_out) begin
                        state_reg <= rnd_data_out;
                        if (rcnt == LAST_ROUND) begin
                            state <= DONE;
                        end else begin
                            rcnt  <= rcnt + 4'd1;
                            state <= ISSUE;
                        end
                    end else if (wcnt == WCNT_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state == IDLE);
    assign busy          = (state != IDLE);
    assign rnd_valid_in  = (state == ISSUE);
    assign rnd_key_valid = rnd_valid_in;
    assign rnd_final     = rnd_valid_in && (rcnt == LAST_ROUND);
    assign key_idx       = rnd_valid_in ? rcnt : 4'd0;
    assign rnd_data_in   = state_reg;
    assign rnd_key       = key_data;
    assign out_valid     = (state == DONE);
    assign out_data      = state_reg;

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: AES-128 key store and variable-latency round datapath model,
// with a scoreboard of reference ciphertexts checked by an independent output monitor.
module tb_aes_round_sched;

    localparam int DL = 128;
    localparam int NR = 10;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DL-1:0] in_data;
    logic [3:0]    key_idx;
    logic [DL-1:0] key_data;
    logic          rnd_valid_in;
    logic [DL-1:0] rnd_data_in;
    logic          rnd_key_valid;
    logic [DL-1:0] rnd_key;
    logic          rnd_final;
    logic          rnd_valid_out;
    logic [DL-1:0] rnd_data_out;
    logic          out_valid;
    logic          out_ready;
    logic [DL-1:0] out_data;
    logic          busy;
    logic          err_timeout;
    logic          err_spurious;

    aes_round_sched #(.DATA_LEN(DL), .NR(NR), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .key_idx(key_idx), .key_data(key_data),
        .rnd_valid_in(rnd_valid_in), .rnd_data_in(rnd_data_in),
        .rnd_key_valid(rnd_key_valid), .rnd_key(rnd_key), .rnd_final(rnd_final),
        .rnd_valid_out(rnd_valid_out), .rnd_data_out(rnd_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    logic [7:0]    sbox [256];
    logic [DL-1:0] key_store [0:15];
    assign key_data = key_store[key_idx];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    logic [DL-1:0] exp_q [$];
    int  cur_lat = 4;
    int  drop_round = 0;
    bit  spur_req = 1'b0;
    bit  expect_b2b = 1'b0;
    int  acc_cyc = 0;
    int  acc_lat = 0;
    int  exp_round = 1;
    int  hs_cyc = 0;
    logic          prev_ov = 1'b0;
    logic          prev_or = 1'b0;
    logic [DL-1:0] prev_od = '0;

    task automatic check(input string name, input logic [DL-1:0] act, input logic [DL-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- AES reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] p;
        logic       hi;
        x = a;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            hi = x[7];
            x  = {x[6:0], 1'b0};
            if (hi) x ^= 8'h1b;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic [DL-1:0] aes_round(input logic [DL-1:0] s, input logic [DL-1:0] k,
                                                input logic fin);
        logic [7:0]    b [16];
        logic [7:0]    t [16];
        logic [7:0]    a0, a1, a2, a3;
        logic [DL-1:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
                t[row+4*c] = b[row + 4*((c + row) % 4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
        return r ^ k;
    endfunction

    function automatic logic [DL-1:0] aes_ref(input logic [DL-1:0] pt);
        logic [DL-1:0] s;
        s = pt ^ key_store[0];
        for (int r = 1; r <= NR; r++) s = aes_round(s, key_store[r], r == NR);
        return s;
    endfunction

    task automatic expand_key(input logic [DL-1:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]}
                      ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= NR; r++) key_store[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [DL-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- cycle counter ----------------
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- round datapath model ----------------
    initial begin
        int            dp_cnt;
        bit            dp_pend;
        logic [DL-1:0] dp_res;
        rnd_valid_out = 1'b0;
        rnd_data_out  = '0;
        dp_pend = 1'b0;
        dp_cnt  = 0;
        dp_res  = '0;
        forever begin
            @(negedge clk);
            rnd_valid_out = 1'b0;
            if (reset) begin
                dp_pend = 1'b0;
            end else begin
                if (dp_pend) begin
                    dp_cnt--;
                    if (dp_cnt == 0) begin
                        rnd_valid_out = 1'b1;
                        rnd_data_out  = dp_res;
                        dp_pend       = 1'b0;
                    end
                end
                if (spur_req) begin
                    rnd_valid_out = 1'b1;
                    rnd_data_out  = rnd128();
                end
                if (rnd_valid_in && (int'(key_idx) != drop_round)) begin
                    dp_pend = 1'b1;
                    dp_cnt  = cur_lat;
                    dp_res  = aes_round(rnd_data_in, rnd_key, rnd_final);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        @(negedge clk);
        if (reset) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                check("accept_key_idx", key_idx, 0);
                acc_cyc   = cyc;
                acc_lat   = cur_lat;
                exp_round = 1;
                if (expect_b2b) begin
                    check("b2b_accept_cycle", cyc, hs_cyc + 1);
                    expect_b2b = 1'b0;
                end
            end
            if (rnd_valid_in) begin
                check("issue_key_idx", key_idx, exp_round);
                check("issue_rnd_key", rnd_key, key_store[exp_round]);
                check("issue_key_valid", rnd_key_valid, 1);
                check("issue_final", rnd_final, exp_round == NR);
                exp_round++;
            end else begin
                check("idle_launch_lines", {rnd_key_valid, rnd_final}, 0);
            end
            if (out_valid && !prev_ov)
                check("out_latency", cyc - acc_cyc, NR * (acc_lat + 1) + 1);
            if (prev_ov && !prev_or) begin
                check("hold_out_valid", out_valid, 1);
                check("hold_out_data", out_data, prev_od);
                check("hold_in_ready", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                check("output_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("ciphertext", out_data, exp_q.pop_front());
                hs_cyc = cyc;
            end
            prev_ov = out_valid;
            prev_or = out_ready;
            prev_od = out_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset(input string pfx);
        check({pfx, "_in_ready"}, in_ready, 1);
        check({pfx, "_out_valid"}, out_valid, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_launch"}, {rnd_valid_in, rnd_key_valid, rnd_final}, 0);
        check({pfx, "_key_idx"}, key_idx, 0);
        check({pfx, "_errs"}, {err_timeout, err_spurious}, 0);
        check({pfx, "_out_data"}, out_data, 0);
        check({pfx, "_rnd_data_in"}, rnd_data_in, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after the accept edge.
    task automatic send(input logic [DL-1:0] pt, input logic [DL-1:0] exp, input bit push);
        int n;
        in_data  = pt;
        in_valid = 1'b1;
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
        end
        if (n >= 500) check("accept_timeout", in_ready, 1);
        if (push) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = rnd128();
    endtask

    task automatic wait_idle(input string name);
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        if (n >= 2000) check(name, busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DL-1:0] pt;
        logic [DL-1:0] od;
        int            n;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 16; i++) key_store[i] = '0;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // FIPS-197 C.1 known-answer vector, L = 4.
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        cur_lat = 4;
        send(128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b1);
        wait_idle("c1_complete");

        // Back-pressure for 20 cycles, then a back-to-back second block.
        out_ready = 1'b0;
        pt = rnd128();
        send(pt, aes_ref(pt), 1'b1);
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        if (n >= 500) check("bp_out_valid_rise", out_valid, 1);
        repeat (20) @(posedge clk);
        #1;
        out_ready  = 1'b1;
        expect_b2b = 1'b1;
        pt = rnd128();
        send(pt, aes_ref(pt), 1'b1);
        wait_idle("b2b_complete");

        // Random keys, plaintexts and datapath latencies.
        for (int k = 0; k < 6; k++) begin
            expand_key(rnd128());
            cur_lat = $urandom_range(1, 6);
            pt = rnd128();
            send(pt, aes_ref(pt), 1'b1);
            wait_idle("random_complete");
        end

        // Timeout: the round-3 result never comes back.
        cur_lat    = 4;
        drop_round = 3;
        check("timeout_flag_before", err_timeout, 0);
        send(rnd128(), '0, 1'b0);
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        check("timeout_idle_cycle", cyc - acc_cyc, 2 * (4 + 1) + TO + 2);
        check("timeout_flag", err_timeout, 1);
        check("timeout_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        drop_round = 0;
        pt = rnd128();
        send(pt, aes_ref(pt), 1'b1);
        wait_idle("after_timeout_complete");
        check("timeout_flag_sticky", err_timeout, 1);

        // Spurious round result while idle.
        check("spurious_flag_before", err_spurious, 0);
        od = out_data;
        spur_req = 1'b1;
        @(posedge clk);
        #1;
        spur_req = 1'b0;
        @(negedge clk);
        check("spurious_flag", err_spurious, 1);
        check("spurious_busy", busy, 0);
        check("spurious_in_ready", in_ready, 1);
        check("spurious_state_reg", out_data, od);
        @(posedge clk);
        #1;

        // Reset during the round-5 WAIT.
        cur_lat = 4;
        pt = rnd128();
        send(pt, aes_ref(pt), 1'b1);
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (rnd_valid_in === 1'b1 && key_idx == 4'd5) break;
        end
        if (n >= 500) check("round5_launch", key_idx, 5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("midop");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        pt = rnd128();
        send(pt, aes_ref(pt), 1'b1);
        wait_idle("after_reset_complete");

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
